shift_request_sequencer: RTL and testbench

- Sequential front-end that feeds the team's 8-bit combinational bidirectional barrel shifter and collects what it produces.
- Accepts shift requests on a valid/ready stream and buffers them in a small FIFO.
- Splits each total shift amount (0..15) into passes of at most 7 through the shifter, one pass per cycle, and returns the result on a registered valid/ready output.
- Sits between the request producer and the shifter stage. The shifter itself sits outside this block and is reached through the sh_* ports.

---
 rtl/shift_request_sequencer_pkg.sv | 15 +
 rtl/shift_request_sequencer_if.sv | 36 +++
 rtl/shift_req_fifo.sv | 61 ++++++
 rtl/shift_request_sequencer.sv | 141 ++++++++++++++
 tb/tb_shift_request_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_request_sequencer_pkg.sv
// Shared types and constants for the shift request sequencer.
// Holds the FSM encoding and shifter pass limits.
package shift_request_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [2:0] MAX_STEP  = 3'd7;
    localparam logic       DIR_LEFT  = 1'b1;
    localparam logic       DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_request_sequencer_if.sv
// Request, result and shifter-side signals of the sequencer.
// slave is the sequencer view, master the surrounding logic.
interface shift_request_sequencer_if #(
    parameter int AMT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [7:0]       sh_data;
    logic [2:0]       sh_shamt;
    logic             sh_dir;
    logic [7:0]       sh_result;

    modport slave (
        input  in_valid, in_data, in_amt, in_dir,
        output in_ready,
        output out_valid, out_data,
        input  out_ready,
        output sh_data, sh_shamt, sh_dir,
        input  sh_result
    );

    modport master (
        output in_valid, in_data, in_amt, in_dir,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready,
        input  sh_data, sh_shamt, sh_dir,
        output sh_result
    );
endinterface

// File: rtl/shift_req_fifo.sv
// Small request FIFO: power-of-two depth, count-based full/empty.
// Push when full and pop when empty are ignored.
module shift_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/shift_request_sequencer.sv
// Buffers shift requests and runs each through the external shifter
// in passes of at most MAX_STEP, returning a registered result.
module shift_request_sequencer
    import shift_request_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AMT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    shift_request_sequencer_if.slave  io,
    output logic                      busy
);
    localparam int FW = 9 + AMT_W;

    state_t           state;
    state_t           state_next;
    logic [7:0]       work_data;
    logic [AMT_W-1:0] rem;
    logic             work_dir;
    logic [7:0]       out_data_q;
    logic             out_valid_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             load;
    logic             pass_done;
    logic [FW-1:0]    fifo_wdata;
    logic [FW-1:0]    fifo_rdata;
    logic [2:0]       step;
    logic [AMT_W-1:0] rem_after;

    assign io.in_ready = rst_n & ~fifo_full;
    assign push        = io.in_valid & io.in_ready;
    assign fifo_wdata  = {io.in_dir, io.in_amt, io.in_data};

    shift_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Clamp the remaining distance to what one pass can do
    always_comb begin
        step = MAX_STEP;
        if (rem <= AMT_W'(MAX_STEP)) begin
            step = rem[2:0];
        end
    end

    assign rem_after = rem - AMT_W'(step);

    // Next state, FIFO pop and work-register load decisions
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        pass_done  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (rem_after == '0) begin
                    pass_done  = 1'b1;
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (io.out_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        load       = 1'b1;
                        state_next = ST_EXEC;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Work registers: load from FIFO head, then fold in each pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_data <= '0;
            rem       <= '0;
            work_dir  <= DIR_RIGHT;
        end else if (load) begin
            work_data <= fifo_rdata[7:0];
            rem       <= fifo_rdata[8 +: AMT_W];
            work_dir  <= fifo_rdata[FW-1];
        end else if (state == ST_EXEC) begin
            work_data <= io.sh_result;
            rem       <= rem_after;
        end
    end

    // Result register held until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (pass_done) begin
            out_data_q  <= io.sh_result;
            out_valid_q <= 1'b1;
        end else if (state == ST_OUT && io.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.sh_data   = work_data;
    assign io.sh_dir    = work_dir;
    assign io.sh_shamt  = (state == ST_EXEC) ? step : 3'd0;
    assign busy         = ~fifo_empty | (state != ST_IDLE);
endmodule

// File: tb/tb_shift_request_sequencer.sv
// Bench for shift_request_sequencer with a behavioural shifter
// on the sh_* ports and a queue of expected results.
module tb_shift_request_sequencer;
    import shift_request_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] sb [$];

    shift_request_sequencer_if #(.AMT_W(4)) io ();

    shift_request_sequencer #(
        .DEPTH (4),
        .AMT_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (io.sh_dir) io.sh_result = io.sh_data << io.sh_shamt;
        else           io.sh_result = io.sh_data >> io.sh_shamt;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        io.in_valid = 1'b0;
        io.in_data = '0;
        io.in_amt = '0;
        io.in_dir = 1'b0;
        io.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_ready: got %b expected 0", io.in_ready);
        end
        checks++;
        if (io.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_valid: got %b expected 0", io.out_valid);
        end
        checks++;
        if (io.out_data !== 8'h00) begin
            failures++;
            $display("FAIL rst_out_data: got %h expected 00", io.out_data);
        end
        checks++;
        if ({io.sh_data, io.sh_shamt, io.sh_dir} !== 12'h000) begin
            failures++;
            $display("FAIL rst_sh: got %h/%0d/%b expected 00/0/0",
                     io.sh_data, io.sh_shamt, io.sh_dir);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy: got %b expected 0", busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rel_in_ready: got %b expected 1", io.in_ready);
        end
    endtask

    task automatic test_single(input logic [7:0] d, input logic [3:0] a,
                               input logic dir, input logic [7:0] exp,
                               input string name);
        int         steps [$];
        logic [7:0] datas [$];
        int         rem;
        int         st;
        int         cyc;
        int         idx;
        bit         got;
        logic [7:0] cur;
        logic [7:0] want;
        rem = int'(a);
        cur = d;
        do begin
            st = (rem > 7) ? 7 : rem;
            steps.push_back(st);
            datas.push_back(cur);
            cur = dir ? (cur << st) : (cur >> st);
            rem -= st;
        end while (rem != 0);
        @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_in_ready: got %b expected 1", name, io.in_ready);
        end
        io.in_valid = 1'b1;
        io.in_data = d;
        io.in_amt = a;
        io.in_dir = dir;
        io.out_ready = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        io.in_valid = 1'b0;
        cyc = 1;
        checks++;
        if (io.sh_shamt !== 3'd0) begin
            failures++;
            $display("FAIL %s_idle_shamt: got %0d expected 0", name, io.sh_shamt);
        end
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            idx = cyc - 2;
            if (io.out_valid === 1'b1) begin
                got = 1'b1;
            end else if (idx >= 0 && idx < steps.size()) begin
                checks++;
                if (io.sh_shamt !== 3'(steps[idx]) || io.sh_data !== datas[idx]) begin
                    failures++;
                    $display("FAIL %s_pass%0d: got shamt %0d data %h expected %0d %h",
                             name, idx, io.sh_shamt, io.sh_data, steps[idx], datas[idx]);
                end
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout: got no out_valid expected one by cycle 20", name);
        end else begin
            if (cyc !== 2 + steps.size()) begin
                failures++;
                $display("FAIL %s_latency: got %0d expected %0d", name, cyc, 2 + steps.size());
            end
            want = sb.pop_front();
            checks++;
            if (io.out_data !== want) begin
                failures++;
                $display("FAIL %s_data: got %h expected %h", name, io.out_data, want);
            end
        end
        @(negedge clk);
        checks++;
        if (io.out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain: got valid %b busy %b expected 0 0",
                     name, io.out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int         acc;
        int         n;
        int         last;
        logic [7:0] want;
        logic       exp_rdy;
        acc = 0;
        io.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_rdy = (i < 5);
            checks++;
            if (io.in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL bp_in_ready%0d: got %b expected %b", i, io.in_ready, exp_rdy);
            end
            io.in_valid = 1'b1;
            io.in_data = 8'h10 + 8'(i);
            io.in_amt = 4'd1;
            io.in_dir = DIR_LEFT;
            if (io.in_ready === 1'b1) begin
                sb.push_back((8'h10 + 8'(i)) << 1);
                acc++;
            end
        end
        @(negedge clk);
        io.in_valid = 1'b0;
        checks++;
        if (acc !== 5) begin
            failures++;
            $display("FAIL bp_accepted: got %0d expected 5", acc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (io.out_valid !== 1'b1 || io.out_data !== 8'h20) begin
            failures++;
            $display("FAIL bp_hold: got valid %b data %h expected 1 20",
                     io.out_valid, io.out_data);
        end
        io.out_ready = 1'b1;
        n = 0;
        last = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (io.out_valid === 1'b1) begin
                want = sb.pop_front();
                checks++;
                if (io.out_data !== want) begin
                    failures++;
                    $display("FAIL bp_data%0d: got %h expected %h", n, io.out_data, want);
                end
                if (n > 0) begin
                    checks++;
                    if (c - last !== 2) begin
                        failures++;
                        $display("FAIL bp_gap%0d: got %0d expected 2", n, c - last);
                    end
                end
                last = c;
                n++;
            end
        end
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL bp_count: got %0d expected 5", n);
        end
        @(negedge clk);
        checks++;
        if (io.out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: got valid %b busy %b expected 0 0", io.out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int stale;
        io.out_ready = 1'b1;
        @(negedge clk);
        io.in_valid = 1'b1;
        io.in_data = 8'h3C;
        io.in_amt = 4'd9;
        io.in_dir = DIR_LEFT;
        sb.push_back(8'h00);
        @(negedge clk);
        io.in_data = 8'h11;
        io.in_amt = 4'd2;
        io.in_dir = DIR_RIGHT;
        sb.push_back(8'h04);
        @(negedge clk);
        io.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (io.sh_shamt !== 3'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: got shamt %0d busy %b expected 2 1", io.sh_shamt, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (io.out_valid !== 1'b0 || busy !== 1'b0 || io.in_ready !== 1'b0 ||
            io.sh_shamt !== 3'd0) begin
            failures++;
            $display("FAIL mid_rst: got valid %b busy %b ready %b shamt %0d expected 0 0 0 0",
                     io.out_valid, busy, io.in_ready, io.sh_shamt);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_rel_ready: got %b expected 1", io.in_ready);
        end
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (io.out_valid !== 1'b0 || busy !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL mid_stale: got %0d active cycles expected 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_single(8'hB5, 4'd3, DIR_LEFT, 8'hA8, "b5_l3");
        test_single(8'hB5, 4'd3, DIR_RIGHT, 8'h16, "b5_r3");
        test_single(8'h5A, 4'd0, DIR_LEFT, 8'h5A, "5a_l0");
        test_single(8'h81, 4'd8, DIR_LEFT, 8'h00, "81_l8");
        test_single(8'hFF, 4'd15, DIR_RIGHT, 8'h00, "ff_r15");
        test_backpressure();
        test_reset_mid();
        test_single(8'hC3, 4'd2, DIR_RIGHT, 8'h30, "c3_r2");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
